ahb_to_apb_bridge: RTL

//  AHB-Lite slave that converts core transfers into APB4 accesses. Sits directly downstream of the

---
 rtl/ahb_to_apb_bridge_if.sv | 44 ++++
 rtl/ahb_to_apb_bridge.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ahb_to_apb_bridge_if.sv
// ahb_to_apb_bridge_if: AHB-Lite slave-side and APB4 master-side signals of the bridge.
// The slave modport is the bridge's view; the master modport is the surrounding system
// (AHB master/decoder plus the APB peripheral).
interface ahb_to_apb_bridge_if #(
    parameter int ADDR_WIDTH = 16
);
    // AHB-Lite side
    logic                  HSEL;
    logic [31:0]           HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [3:0]            HPROT;
    logic [31:0]           HWDATA;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic [31:0]           HRDATA;
    logic                  HRESP;
    // APB4 side
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [31:0]           PWDATA;
    logic [3:0]            PSTRB;
    logic [2:0]            PPROT;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA, HREADY,
        input  PRDATA, PREADY, PSLVERR,
        output HREADYOUT, HRDATA, HRESP,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA, HREADY,
        output PRDATA, PREADY, PSLVERR,
        input  HREADYOUT, HRDATA, HRESP,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT
    );
endinterface

// File: rtl/ahb_to_apb_bridge.sv
// ahb_to_apb_bridge: AHB-Lite slave converting each accepted transfer into one APB4 access.
// Optional feature macro: APB_TIMEOUT_EN -- bounds the ACCESS-phase wait to TIMEOUT_CYCLES
// cycles and turns an expired wait into an AHB ERROR response.
// All outputs except PWDATA are registered; PWDATA is HWDATA passed straight through.
module ahb_to_apb_bridge #(
    parameter int ADDR_WIDTH = 16
`ifdef APB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input logic                HCLK,
    input logic                HRESET,
    ahb_to_apb_bridge_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       accept;
    logic       illegal;
    logic       timeout;
    logic [3:0] strb;
    logic       psel_next;
    logic       penable_next;
    logic       hreadyout_next;
    logic       hresp_next;
    logic       unused_bits;

    assign unused_bits = &{1'b0, bus.HTRANS[0], bus.HPROT[3:2], bus.HADDR};

    assign bus.PWDATA = bus.HWDATA;

    assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY &
                    ((state == IDLE) | (state == ERR2));

    // Decode size/alignment into an illegal flag and the write byte strobes.
    always_comb begin
        illegal = 1'b0;
        strb    = '0;
        case (bus.HSIZE)
            3'd0: strb = 4'b0001 << bus.HADDR[1:0];
            3'd1: begin
                strb    = bus.HADDR[1] ? 4'b1100 : 4'b0011;
                illegal = bus.HADDR[0];
            end
            3'd2: begin
                strb    = '1;
                illegal = |bus.HADDR[1:0];
            end
            default: illegal = 1'b1;
        endcase
    end

`ifdef APB_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Count ACCESS cycles spent waiting on PREADY; restart for every new APB access.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wait_cnt <= '0;
        end else if (state_next == SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !bus.PREADY) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // The cycle that would bring the count to TIMEOUT_CYCLES is the last one waited.
    assign timeout = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register; bus control outputs are registered alongside it from the next state.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state         <= IDLE;
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.HREADYOUT <= 1'b1;
            bus.HRESP     <= 1'b0;
        end else begin
            state         <= state_next;
            bus.PSEL      <= psel_next;
            bus.PENABLE   <= penable_next;
            bus.HREADYOUT <= hreadyout_next;
            bus.HRESP     <= hresp_next;
        end
    end

    // Next-state logic; ERR2 behaves like IDLE for accepting the next transfer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, ERR2: begin
                if (accept) begin
                    state_next = illegal ? ERR1 : SETUP;
                end else begin
                    state_next = IDLE;
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                if (bus.PREADY) begin
                    state_next = bus.PSLVERR ? ERR1 : IDLE;
                end else if (timeout) begin
                    state_next = ERR1;
                end
            end
            ERR1:    state_next = ERR2;
            default: state_next = IDLE;
        endcase
    end

    // Output decode of the next state, so the registered outputs line up with the state.
    always_comb begin
        psel_next      = 1'b0;
        penable_next   = 1'b0;
        hreadyout_next = 1'b1;
        hresp_next     = 1'b0;
        case (state_next)
            SETUP: begin
                psel_next      = 1'b1;
                hreadyout_next = 1'b0;
            end
            ACCESS: begin
                psel_next      = 1'b1;
                penable_next   = 1'b1;
                hreadyout_next = 1'b0;
            end
            ERR1: begin
                hresp_next     = 1'b1;
                hreadyout_next = 1'b0;
            end
            ERR2: hresp_next = 1'b1;
            default: ;
        endcase
    end

    // Capture APB address/control on a legal accept; latch read data on a clean read completion.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            bus.PADDR  <= '0;
            bus.PWRITE <= 1'b0;
            bus.PSTRB  <= '0;
            bus.PPROT  <= '0;
            bus.HRDATA <= '0;
        end else begin
            if (accept && !illegal) begin
                bus.PADDR  <= bus.HADDR[ADDR_WIDTH-1:0];
                bus.PWRITE <= bus.HWRITE;
                bus.PSTRB  <= bus.HWRITE ? strb : 4'b0000;
                bus.PPROT  <= {~bus.HPROT[0], 1'b0, bus.HPROT[1]};
            end
            if ((state == ACCESS) && bus.PREADY && !bus.PSLVERR && !bus.PWRITE) begin
                bus.HRDATA <= bus.PRDATA;
            end
        end
    end
endmodule
